// File: rtl/frame_capture_pkg.sv
// rtl/frame_capture_pkg.sv - shared types, state encodings and frame sizing helper for frame_capture_ctrl
package frame_capture_pkg;

    typedef logic [7:0] rgb332_t;

    // Encodings are fixed so that state values stay readable in existing waveforms and scripts.
    typedef logic [2:0] fc_state_t;
    localparam fc_state_t ST_IDLE      = 3'd0;
    localparam fc_state_t ST_WAIT_SOF  = 3'd1;
    localparam fc_state_t ST_SKIP      = 3'd2;
    localparam fc_state_t ST_WAIT_SOF2 = 3'd3;
    localparam fc_state_t ST_CAPTURE   = 3'd4;
    localparam fc_state_t ST_DONE      = 3'd5;

    localparam int DEF_H_PIX    = 640;
    localparam int DEF_V_PIX    = 240;
    localparam int FRAME_PIXELS = DEF_H_PIX * DEF_V_PIX;

    function automatic int frame_pixels(input int h_pix, input int v_pix);
        return h_pix * v_pix;
    endfunction

endpackage

// File: rtl/fc_read_addr.sv
// rtl/fc_read_addr.sv - registered display coordinate to buffer read address stage
// Ports:
//   clk, resetn          pixel clock, asynchronous active-low reset
//   done                 buffer holds a complete frame
//   rd_x, rd_y           display coordinates
//   buf_raddr, rd_valid  read address and validity, one cycle after rd_x/rd_y
module fc_read_addr #(
    parameter int H_PIX  = 640,
    parameter int V_PIX  = 240,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              done,
    input  logic [9:0]        rd_x,
    input  logic [9:0]        rd_y,
    output logic [ADDR_W-1:0] buf_raddr,
    output logic              rd_valid
);

    logic              in_range;
    logic [ADDR_W-1:0] raddr_d;
    logic [ADDR_W-1:0] raddr_q;
    logic              valid_q;

    assign in_range = (32'(rd_x) < H_PIX) && (32'(rd_y) < V_PIX);

    // Unsigned row-major address, deliberately computed modulo 2^ADDR_W.
    assign raddr_d = in_range ? (ADDR_W'(rd_y) * ADDR_W'(H_PIX) + ADDR_W'(rd_x)) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            raddr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            raddr_q <= raddr_d;
            valid_q <= done & in_range;
        end
    end

    assign buf_raddr = raddr_q;
    assign rd_valid  = valid_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - arms, skips warm-up frames and captures one RGB332 frame into the buffer
// Optional feature macro: FRAME_CAPTURE_LINE_ALIGN_EN (line_start snaps writes to the next buffer row).
// Ports:
//   clk, resetn                         pixel clock, asynchronous active-low reset
//   arm                                 capture request pulse
//   frame_start, frame_end, line_start  CSI-2 short packet pulses
//   pix_valid, pix_data                 pixel strobe and RGB332 data
//   rd_x, rd_y                          display coordinates
//   buf_we, buf_waddr, buf_wdata        buffer write port
//   buf_raddr, rd_valid                 buffer read address and validity
//   busy, done, short_frame             status
module frame_capture_ctrl
    import frame_capture_pkg::*;
#(
    parameter int H_PIX       = DEF_H_PIX,
    parameter int V_PIX       = DEF_V_PIX,
    parameter int ADDR_W      = 18,
    parameter int SKIP_FRAMES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arm,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              line_start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    input  logic [9:0]        rd_x,
    input  logic [9:0]        rd_y,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [7:0]        buf_wdata,
    output logic [ADDR_W-1:0] buf_raddr,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              short_frame
);

    // One extra bit so the counter can sit at FRAME_PIX without wrapping.
    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(frame_pixels(H_PIX, V_PIX));
    localparam int              SKIP_W    = $clog2(SKIP_FRAMES + 1) + 1;

    fc_state_t         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              done_q, done_d;
    logic              short_q, short_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    rgb332_t           wdata_q, wdata_d;
    logic              accept;

`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
    localparam int    COL_W = $clog2(H_PIX + 1);
    logic [COL_W-1:0] col_q, col_d;
`else
    logic unused_line_start;
    assign unused_line_start = line_start;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        skip_d  = skip_q;
        done_d  = done_q;
        short_d = short_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        accept  = 1'b0;
`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
        col_d   = col_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_WAIT_SOF;
                    done_d  = 1'b0;
                    short_d = 1'b0;
                    skip_d  = '0;
                end
            end
            ST_WAIT_SOF: begin
                if (frame_start) begin
                    if (SKIP_FRAMES > 0) begin
                        state_d = ST_SKIP;
                    end else begin
                        state_d = ST_CAPTURE;
                        count_d = '0;
`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
                        col_d   = '0;
`endif
                    end
                end
            end
            ST_SKIP: begin
                if (frame_end) begin
                    skip_d = skip_q + 1'b1;
                    if (skip_q + 1'b1 == SKIP_W'(SKIP_FRAMES)) begin
                        state_d = ST_WAIT_SOF2;
                    end
                end
            end
            ST_WAIT_SOF2: begin
                if (frame_start) begin
                    state_d = ST_CAPTURE;
                    count_d = '0;
`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
                    col_d   = '0;
`endif
                end
            end
            ST_CAPTURE: begin
                // A fresh frame_start abandons the partial frame; otherwise a
                // line_start rounds the counter up to the next row boundary.
                if (frame_start) begin
                    count_d = '0;
`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
                    col_d   = '0;
                end else if (line_start) begin
                    // col_q == 0 means already aligned (or just entered); col_q == H_PIX adds zero.
                    if (col_q != '0) begin
                        count_d = count_q + CNT_W'(H_PIX) - CNT_W'(col_q);
                    end
                    col_d = '0;
`endif
                end
`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
                accept = pix_valid && (count_d < FRAME_PIX) && (32'(col_d) < H_PIX);
`else
                accept = pix_valid && (count_d < FRAME_PIX);
`endif
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = count_d[ADDR_W-1:0];
                    wdata_d = pix_data;
                    count_d = count_d + 1'b1;
`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
                    col_d   = col_d + 1'b1;
`endif
                end
                // The coincident pixel above is already counted before the short check.
                if (frame_end) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (count_d < FRAME_PIX) begin
                        short_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            skip_q  <= '0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
            col_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            skip_q  <= skip_d;
            done_q  <= done_d;
            short_q <= short_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
            col_q   <= col_d;
`endif
        end
    end

    assign buf_we      = we_q;
    assign buf_waddr   = waddr_q;
    assign buf_wdata   = wdata_q;
    assign done        = done_q;
    assign short_frame = short_q;
    assign busy        = (state_q == ST_WAIT_SOF) || (state_q == ST_SKIP) ||
                         (state_q == ST_WAIT_SOF2) || (state_q == ST_CAPTURE);

    fc_read_addr #(
        .H_PIX  (H_PIX),
        .V_PIX  (V_PIX),
        .ADDR_W (ADDR_W)
    ) u_read_addr (
        .clk       (clk),
        .resetn    (resetn),
        .done      (done_q),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .buf_raddr (buf_raddr),
        .rd_valid  (rd_valid)
    );

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - scoreboard testbench for frame_capture_ctrl on a reduced 8x4 frame
module tb_frame_capture_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 6;
    localparam int SK = 2;
    localparam int FP = H * V;

    logic          clk = 1'b0;
    logic          resetn;
    logic          arm, fs, fe, ls, pix_valid;
    logic [7:0]    pix_data;
    logic [9:0]    rd_x, rd_y;
    logic          buf_we;
    logic [AW-1:0] buf_waddr, buf_raddr;
    logic [7:0]    buf_wdata;
    logic          rd_valid, busy, done, short_frame;

    int            checks = 0;
    int            errors = 0;
    int            wr_cnt = 0;
    int            m_cnt  = 0;
    bit            m_cap  = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] mon_e;

    frame_capture_ctrl #(
        .H_PIX       (H),
        .V_PIX       (V),
        .ADDR_W      (AW),
        .SKIP_FRAMES (SK)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .arm         (arm),
        .frame_start (fs),
        .frame_end   (fe),
        .line_start  (ls),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .buf_we      (buf_we),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .buf_raddr   (buf_raddr),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
        .short_frame (short_frame)
    );

    always #5 clk = ~clk;

    // Write monitor: every buf_we must match the oldest expected write.
    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h, required no write", buf_waddr, buf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({buf_waddr, buf_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %0h, required addr %0d data %0h",
                             buf_waddr, buf_wdata, mon_e[AW+7:8], mon_e[7:0]);
                end
            end
            last_addr = buf_waddr;
            wr_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // One camera frame: FS, npix pixels in rows of H (LS on each row's first pixel), FE.
    task automatic frame(input int idx, input int npix, input bit cap, input bit fe_with_last);
        fs = 1'b1;
        m_cap = cap;
        m_cnt = 0;
        step();
        fs = 1'b0;
        for (int i = 0; i < npix; i++) begin
            ls        = (i % H == 0);
            pix_valid = 1'b1;
            pix_data  = 8'((idx << 5) | (i & 31));
            if (m_cap && m_cnt < FP) begin
                exp_q.push_back({AW'(m_cnt), pix_data});
                m_cnt++;
            end
            fe = fe_with_last && (i == npix - 1);
            step();
            ls = 1'b0;
            pix_valid = 1'b0;
            fe = 1'b0;
        end
        if (!fe_with_last) begin
            fe = 1'b1;
            step();
            fe = 1'b0;
        end
        step();
        m_cap = 1'b0;
    endtask

    task automatic skip_two();
        frame(0, FP, 1'b0, 1'b0);
        frame(1, FP, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        arm = 1'b0; fs = 1'b0; fe = 1'b0; ls = 1'b0;
        pix_valid = 1'b0; pix_data = '0; rd_x = '0; rd_y = '0;
        step();
        step();
        chk("reset_buf_we", 32'(buf_we), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_short", 32'(short_frame), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_raddr", 32'(buf_raddr), 0);
        resetn = 1'b1;
        step();
        chk("idle_rd_valid_no_frame", 32'(rd_valid), 0);

        // Skip two frames, capture the third; a stray arm while busy must change nothing.
        arm_pulse();
        chk("busy_after_arm", 32'(busy), 1);
        frame(0, FP, 1'b0, 1'b0);
        arm_pulse();
        frame(1, FP, 1'b0, 1'b0);
        wr_cnt = 0;
        frame(2, FP, 1'b1, 1'b0);
        chk("full_done", 32'(done), 1);
        chk("full_short", 32'(short_frame), 0);
        chk("full_busy_idle", 32'(busy), 0);
        chk("full_writes", 32'(wr_cnt), FP);
        chk("full_last_addr", 32'(last_addr), FP - 1);

        // Read path: 2*8+5 = 21, last pixel 3*8+7 = 31.
        rd_x = 10'd5; rd_y = 10'd2; step();
        chk("rd_addr_5_2", 32'(buf_raddr), 21);
        chk("rd_valid_5_2", 32'(rd_valid), 1);
        rd_x = 10'd8; step();
        chk("rd_addr_x_oob", 32'(buf_raddr), 0);
        chk("rd_valid_x_oob", 32'(rd_valid), 0);
        rd_x = 10'd7; rd_y = 10'd3; step();
        chk("rd_addr_7_3", 32'(buf_raddr), 31);
        chk("rd_valid_7_3", 32'(rd_valid), 1);
        rd_x = 10'd0; rd_y = 10'd4; step();
        chk("rd_valid_y_oob", 32'(rd_valid), 0);

        // Short frame: FE together with the 20th pixel.
        arm_pulse();
        chk("done_drops_on_arm", 32'(done), 0);
        skip_two();
        wr_cnt = 0;
        frame(2, 20, 1'b1, 1'b1);
        chk("short_done", 32'(done), 1);
        chk("short_flag", 32'(short_frame), 1);
        chk("short_last_addr", 32'(last_addr), 19);
        chk("short_writes", 32'(wr_cnt), 20);

        // Over-long frame: extra pixels dropped, no wrap.
        arm_pulse();
        chk("short_cleared_on_arm", 32'(short_frame), 0);
        skip_two();
        wr_cnt = 0;
        frame(2, FP + 5, 1'b1, 1'b0);
        chk("long_done", 32'(done), 1);
        chk("long_short", 32'(short_frame), 0);
        chk("long_writes", 32'(wr_cnt), FP);
        chk("long_last_addr", 32'(last_addr), FP - 1);

        // Asynchronous reset in the middle of a capture.
        arm_pulse();
        skip_two();
        fs = 1'b1; m_cap = 1'b1; m_cnt = 0;
        step();
        fs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ls = (i % H == 0);
            pix_valid = 1'b1;
            pix_data = 8'(8'hA0 + i);
            exp_q.push_back({AW'(m_cnt), pix_data});
            m_cnt++;
            step();
            ls = 1'b0;
        end
        pix_data = 8'hEE;
        step();
        chk("pre_reset_we", 32'(buf_we), 1);
        resetn = 1'b0;
        #1;
        chk("async_reset_we", 32'(buf_we), 0);
        chk("async_reset_done", 32'(done), 0);
        chk("async_reset_busy", 32'(busy), 0);
        pix_valid = 1'b0;
        m_cap = 1'b0;
        step();
        resetn = 1'b1;
        step();
        arm_pulse();
        skip_two();
        wr_cnt = 0;
        frame(2, FP, 1'b1, 1'b0);
        chk("restart_writes", 32'(wr_cnt), FP);
        chk("restart_done", 32'(done), 1);

`ifdef FRAME_CAPTURE_LINE_ALIGN_EN
        // Rows of 6 pixels land at 0, 8, 16; the 10-pixel row keeps only 8.
        arm_pulse();
        skip_two();
        fs = 1'b1;
        step();
        fs = 1'b0;
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < ((l == 3) ? 10 : 6); i++) begin
                ls = (i == 0);
                pix_valid = 1'b1;
                pix_data = 8'(l * 16 + i);
                if (i < H) exp_q.push_back({AW'(l * H + i), pix_data});
                step();
                ls = 1'b0;
                pix_valid = 1'b0;
            end
        end
        fe = 1'b1;
        step();
        fe = 1'b0;
        step();
        chk("align_done", 32'(done), 1);
        chk("align_short", 32'(short_frame), 0);
        chk("align_last_addr", 32'(last_addr), FP - 1);
`endif

        step();
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
